// File: rtl/alu_reg_pkg.sv
// Shared definitions for the ALU output-register pipeline: payload layout and sizing.
package alu_reg_pkg;

  // Bit positions inside a stage payload {f, cout, ovf, zero, neg}.
  localparam int unsigned PL_NEG   = 0;
  localparam int unsigned PL_ZERO  = 1;
  localparam int unsigned PL_OVF   = 2;
  localparam int unsigned PL_COUT  = 3;
  localparam int unsigned PL_F_LSB = 4;

  // Payload width for a given ALU result width: result plus four flag bits.
  function automatic int unsigned pl_width(input int unsigned width);
    return width + 4;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One pipeline stage: valid bit plus payload, loaded from upstream or cleared.
module alu_pipe_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          clear,
  input  logic          valid_d,
  input  logic [PW-1:0] payload_d,
  output logic          valid_q,
  output logic [PW-1:0] payload_q
);

  // Clear beats load; payload only moves when a real result arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      if (clear) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= valid_d;
      end
      if (load && valid_d && !clear) begin
        payload_q <= payload_d;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_reg.sv
// Elastic DEPTH-stage output register for the ALU result with flags, sticky status and occupancy.
module alu_pipe_reg
  import alu_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           alu_f_in,
  input  logic                       alu_cout_in,
  input  logic                       alu_ovf_in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           f,
  output logic                       cout,
  output logic                       zero,
  output logic                       neg,
  output logic                       ovf,
  output logic                       sticky_cout,
  output logic                       sticky_ovf,
  input  logic                       sticky_clr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PW    = pl_width(WIDTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // Reject configurations that cannot build a pipeline.
  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_cfg
    $error("alu_pipe_reg: WIDTH and DEPTH must both be at least 1");
  end

  logic [DEPTH-1:0]         stage_valid;
  logic [DEPTH-1:0][PW-1:0] stage_pl;
  logic [DEPTH:0]           ready_c;
  logic [PW-1:0]            cap_pl_c;
  logic                     accept_c;
  logic                     deliver_c;

  // Build the captured payload; zero/neg are derived here, never at the output.
  always_comb begin
    cap_pl_c                       = '0;
    cap_pl_c[PL_F_LSB +: WIDTH]    = alu_f_in;
    cap_pl_c[PL_COUT]              = alu_cout_in;
    cap_pl_c[PL_OVF]               = alu_ovf_in;
    cap_pl_c[PL_ZERO]              = (alu_f_in == '0);
    cap_pl_c[PL_NEG]               = alu_f_in[WIDTH-1];
  end

  // Combinational ready chain from the consumer back to the input; empty stages absorb bubbles.
  always_comb begin
    ready_c        = '0;
    ready_c[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      ready_c[i] = !stage_valid[i] || ready_c[i+1];
    end
  end

  assign in_ready  = reset_n && ready_c[0];
  assign accept_c  = in_valid && in_ready && !flush;
  assign deliver_c = out_valid && out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic          v_d;
    logic [PW-1:0] pl_d;

    if (g == 0) begin : g_head
      assign v_d  = in_valid;
      assign pl_d = cap_pl_c;
    end else begin : g_body
      assign v_d  = stage_valid[g-1];
      assign pl_d = stage_pl[g-1];
    end

    alu_pipe_stage #(
      .PW(PW)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (ready_c[g]),
      .clear    (flush),
      .valid_d  (v_d),
      .payload_d(pl_d),
      .valid_q  (stage_valid[g]),
      .payload_q(stage_pl[g])
    );
  end

  // Outputs come straight from the last stage's registers.
  assign out_valid = stage_valid[DEPTH-1];
  assign f         = stage_pl[DEPTH-1][PL_F_LSB +: WIDTH];
  assign cout      = stage_pl[DEPTH-1][PL_COUT];
  assign ovf       = stage_pl[DEPTH-1][PL_OVF];
  assign zero      = stage_pl[DEPTH-1][PL_ZERO];
  assign neg       = stage_pl[DEPTH-1][PL_NEG];

  // Occupancy tracks accepted minus delivered results; flush empties the pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (accept_c && !deliver_c) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (deliver_c && !accept_c) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

  // Sticky status from delivered results; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_cout <= 1'b0;
      sticky_ovf  <= 1'b0;
    end else begin
      if (deliver_c && cout) begin
        sticky_cout <= 1'b1;
      end else if (sticky_clr) begin
        sticky_cout <= 1'b0;
      end
      if (deliver_c && ovf) begin
        sticky_ovf <= 1'b1;
      end else if (sticky_clr) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_reg.sv
// Self-checking bench for alu_pipe_reg against a queue-based reference model.
module tb_alu_pipe_reg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_f_in;
  logic       alu_cout_in;
  logic       alu_ovf_in;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] f;
  logic       cout;
  logic       zero;
  logic       neg;
  logic       ovf;
  logic       sticky_cout;
  logic       sticky_ovf;
  logic       sticky_clr;
  logic [1:0] occupancy;

  alu_pipe_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_f_in   (alu_f_in),
    .alu_cout_in(alu_cout_in),
    .alu_ovf_in (alu_ovf_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .f          (f),
    .cout       (cout),
    .zero       (zero),
    .neg        (neg),
    .ovf        (ovf),
    .sticky_cout(sticky_cout),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: results in flight, oldest first, as {f, cout, ovf},
  // each with the stage position it currently occupies (0 = input side).
  logic [5:0] q_item[$];
  int         q_pos[$];
  bit         m_sc;
  bit         m_so;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_item.delete();
    q_pos.delete();
    m_sc = 1'b0;
    m_so = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance the model past posedge.
  task automatic drive_cycle(input bit iv, input logic [3:0] fv, input bit c, input bit o,
                             input bit fl, input bit ordy, input bit sc);
    bit         exp_ir;
    bit         exp_ov;
    bit         acc;
    bit         del;
    logic [5:0] hd;
    int         prev;
    @(negedge clk);
    in_valid    = iv;
    alu_f_in    = fv;
    alu_cout_in = c;
    alu_ovf_in  = o;
    flush       = fl;
    out_ready   = ordy;
    sticky_clr  = sc;
    #1;
    exp_ir = ordy || (q_item.size() < DEPTH);
    exp_ov = (q_item.size() > 0) && (q_pos[0] == DEPTH - 1);
    hd     = (q_item.size() > 0) ? q_item[0] : 6'd0;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("occupancy", 32'(occupancy), 32'(q_item.size()));
    chk("sticky_cout", 32'(sticky_cout), 32'(m_sc));
    chk("sticky_ovf", 32'(sticky_ovf), 32'(m_so));
    if (exp_ov) begin
      chk("f", 32'(f), 32'(hd[5:2]));
      chk("cout", 32'(cout), 32'(hd[1]));
      chk("ovf", 32'(ovf), 32'(hd[0]));
      chk("zero", 32'(zero), 32'(hd[5:2] == 4'd0));
      chk("neg", 32'(neg), 32'(hd[5]));
    end
    acc = iv && exp_ir && !fl;
    del = exp_ov && ordy;
    @(posedge clk);
    #1;
    if (del) begin
      void'(q_item.pop_front());
      void'(q_pos.pop_front());
    end
    if (del && hd[1]) m_sc = 1'b1;
    else if (sc)      m_sc = 1'b0;
    if (del && hd[0]) m_so = 1'b1;
    else if (sc)      m_so = 1'b0;
    if (fl) begin
      q_item.delete();
      q_pos.delete();
    end else begin
      prev = DEPTH;
      for (int k = 0; k < q_pos.size(); k++) begin
        int np;
        np = q_pos[k] + 1;
        if (np > prev - 1) np = prev - 1;
        q_pos[k] = np;
        prev     = np;
      end
      if (acc) begin
        q_item.push_back({fv, c, o});
        q_pos.push_back(0);
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop before any edge.
  task automatic async_reset(input string tag);
    in_valid   = 1'b0;
    flush      = 1'b0;
    sticky_clr = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, "_f"}, 32'(f), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_sticky_ovf"}, 32'(sticky_ovf), 32'd0);
    chk({tag, "_sticky_cout"}, 32'(sticky_cout), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk({tag, "_in_ready_rel"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n     = 1'b1;
    in_valid    = 1'b1;
    alu_f_in    = 4'hF;
    alu_cout_in = 1'b1;
    alu_ovf_in  = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b1;
    sticky_clr  = 1'b0;
    model_reset();

    // Reset asserted before the first clock edge with an input offered.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("rst_in_ready_rel", 32'(in_ready), 32'd1);

    // Latency and back-to-back stream.
    drive_cycle(1, 4'b1010, 1, 0, 0, 1, 0);
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    drive_cycle(1, 4'b0101, 0, 0, 0, 1, 0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_f", 32'(f), 32'hA);
    chk("lat_cout", 32'(cout), 32'd1);
    chk("lat_zero", 32'(zero), 32'd0);
    chk("lat_neg", 32'(neg), 32'd1);
    drive_cycle(1, 4'b0000, 0, 0, 0, 1, 0);
    chk("stream_f1", 32'(f), 32'h5);
    drive_cycle(0, 4'h0, 0, 0, 0, 1, 0);
    chk("stream_f2", 32'(f), 32'h0);
    chk("stream_zero", 32'(zero), 32'd1);
    drive_cycle(0, 4'h0, 0, 0, 0, 1, 0);
    drive_cycle(0, 4'h0, 0, 0, 0, 1, 0);

    // Backpressure: three results into a two-deep pipe.
    drive_cycle(1, 4'h1, 0, 0, 0, 0, 0);
    drive_cycle(1, 4'h2, 0, 0, 0, 0, 0);
    chk("full_occupancy", 32'(occupancy), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive_cycle(1, 4'h3, 0, 0, 0, 0, 0);
    drive_cycle(1, 4'h3, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 4'h0, 0, 0, 0, 1, 0);

    // Flush with a full pipe and an input offered in the flush cycle.
    drive_cycle(1, 4'hB, 1, 0, 0, 0, 0);
    drive_cycle(1, 4'hC, 0, 1, 0, 0, 0);
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    drive_cycle(1, 4'h7, 0, 0, 1, 0, 0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 4'h0, 0, 0, 0, 1, 0);

    // Sticky set beats a simultaneous clear; a lone clear then clears.
    drive_cycle(1, 4'h3, 0, 1, 0, 1, 0);
    drive_cycle(0, 4'h0, 0, 0, 0, 1, 0);
    drive_cycle(0, 4'h0, 0, 0, 0, 1, 1);
    chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
    drive_cycle(0, 4'h0, 0, 0, 0, 1, 1);
    chk("sticky_cleared", 32'(sticky_ovf), 32'd0);

    // Reset in the middle of a stream with sticky flags set.
    drive_cycle(1, 4'h9, 1, 1, 0, 1, 0);
    drive_cycle(1, 4'h8, 1, 1, 0, 1, 0);
    drive_cycle(1, 4'h6, 1, 1, 0, 1, 0);
    chk("mid_sticky_set", 32'(sticky_ovf), 32'd1);
    async_reset("mid_rst");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 4'($urandom()), 1'($urandom()), 1'($urandom()),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
